// File: rtl/calendar_pkg.sv
// Shared calendar constants and the mod-7 weekday step helper.
package calendar_pkg;

    localparam int DAY_MIN = 1;
    localparam int DAY_MAX = 31;
    localparam int WD_W    = 3;
    localparam int WD_MOD  = 7;

    localparam int DIM_28 = 28;
    localparam int DIM_29 = 29;
    localparam int DIM_30 = 30;
    localparam int DIM_31 = 31;

    // Next weekday for one step; down wins over up, both low holds.
    function automatic logic [WD_W-1:0] wd_next(input logic [WD_W-1:0] wd,
                                                input logic            up,
                                                input logic            down);
        logic [WD_W-1:0] r;
        r = wd;
        if (down) begin
            r = (wd == '0) ? WD_W'(WD_MOD - 1) : wd - WD_W'(1);
        end else if (up) begin
            r = (wd == WD_W'(WD_MOD - 1)) ? '0 : wd + WD_W'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/weekday_ctr.sv
// Mod-7 up/down day-of-week counter.
module weekday_ctr
    import calendar_pkg::*;
#(
    parameter int WD_RESET = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            up,
    input  logic            down,
    output logic [WD_W-1:0] q
);

    // Step the weekday once per applied command; down has priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= WD_W'(WD_RESET);
        end else begin
            q <= wd_next(q, up, down);
        end
    end

endmodule

// File: rtl/counter_ngay.sv
// Day-of-month counter: tracks day and weekday, clamps to the month length,
// and emits a carry toward the month counter on automatic wrap.
module counter_ngay
    import calendar_pkg::*;
#(
    parameter int WD_RESET    = 0,
    parameter int DIM_DEFAULT = 31
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inc_auto,
    input  logic            inc_manual,
    input  logic            dec_manual,
    input  logic [5:0]      dim,
    output logic [4:0]      value,
    output logic            carry_out,
    output logic [WD_W-1:0] weekday,
    output logic            clamp_event
);

    logic [4:0] len_eff;
    logic [4:0] day_eff;
    logic       over;
    logic       do_dec;
    logic       do_inc;
    logic       do_auto;
    logic       any_up;

    // Effective month length, effective day and the prioritised command.
    always_comb begin
        len_eff = 5'(DIM_DEFAULT);
        if (dim >= 6'(DIM_28) && dim <= 6'(DIM_31)) begin
            len_eff = dim[4:0];
        end
        over    = (value > len_eff);
        day_eff = over ? len_eff : value;
        do_dec  = dec_manual;
        do_inc  = !dec_manual && inc_manual;
        do_auto = !dec_manual && !inc_manual && inc_auto;
        any_up  = do_inc || do_auto;
    end

    // Day register plus one-cycle carry and clamp pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value       <= 5'(DAY_MIN);
            carry_out   <= 1'b0;
            clamp_event <= 1'b0;
        end else begin
            carry_out   <= 1'b0;
            clamp_event <= over;
            if (do_dec) begin
                value <= (day_eff == 5'(DAY_MIN)) ? len_eff : day_eff - 5'd1;
            end else if (any_up) begin
                if (day_eff == len_eff) begin
                    value     <= 5'(DAY_MIN);
                    carry_out <= do_auto;
                end else begin
                    value <= day_eff + 5'd1;
                end
            end else begin
                value <= day_eff;
            end
        end
    end

    weekday_ctr #(
        .WD_RESET(WD_RESET)
    ) u_weekday (
        .clk (clk),
        .rst (rst),
        .up  (any_up),
        .down(do_dec),
        .q   (weekday)
    );

endmodule

// File: tb/tb_counter_ngay.sv
// Bench for counter_ngay: reference model feeds an expected queue, plus
// directed checks for rollover, February, clamping and command priority.
module tb_counter_ngay;

    localparam int WD_R = 3;

    logic       clk;
    logic       rst;
    logic       inc_auto;
    logic       inc_manual;
    logic       dec_manual;
    logic [5:0] dim;
    logic [4:0] value;
    logic       carry_out;
    logic [2:0] weekday;
    logic       clamp_event;

    int errors = 0;
    int checks = 0;

    // model state
    int md_v;
    int md_wd;

    // {value, carry, weekday, clamp}
    logic [9:0] exp_q[$];

    counter_ngay #(
        .WD_RESET   (WD_R),
        .DIM_DEFAULT(31)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .inc_auto   (inc_auto),
        .inc_manual (inc_manual),
        .dec_manual (dec_manual),
        .dim        (dim),
        .value      (value),
        .carry_out  (carry_out),
        .weekday    (weekday),
        .clamp_event(clamp_event)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle: model predicts, pushes, drives; compare after the edge.
    task automatic step(input logic ia, input logic im, input logic dm, input int d);
        int   len;
        int   e;
        logic cl;
        logic cy;
        logic [9:0] exp_w;
        logic [9:0] got_w;
        len = (d >= 28 && d <= 31) ? d : 31;
        cl  = (md_v > len);
        e   = cl ? len : md_v;
        cy  = 1'b0;
        if (dm) begin
            md_v  = (e == 1) ? len : e - 1;
            md_wd = (md_wd + 6) % 7;
        end else if (im || ia) begin
            if (e == len) begin
                md_v = 1;
                cy   = ia && !im;
            end else begin
                md_v = e + 1;
            end
            md_wd = (md_wd + 1) % 7;
        end else begin
            md_v = e;
        end
        exp_q.push_back({5'(md_v), cy, 3'(md_wd), cl});
        inc_auto   = ia;
        inc_manual = im;
        dec_manual = dm;
        dim        = 6'(d);
        @(posedge clk);
        #1;
        exp_w = exp_q.pop_front();
        got_w = {value, carry_out, weekday, clamp_event};
        checks++;
        if (got_w !== exp_w) begin
            errors++;
            $display("FAIL step: got value=%0d carry=%0b wd=%0d clamp=%0b, expected value=%0d carry=%0b wd=%0d clamp=%0b",
                     got_w[9:5], got_w[4], got_w[3:1], got_w[0],
                     exp_w[9:5], exp_w[4], exp_w[3:1], exp_w[0]);
        end
        inc_auto   = 1'b0;
        inc_manual = 1'b0;
        dec_manual = 1'b0;
    endtask

    // Walk with inc_manual until the model reaches day v (and weekday w if w>=0).
    task automatic goto_state(input int v, input int w, input int d);
        int n;
        n = 0;
        while (!(md_v == v && (w < 0 || md_wd == w)) && n < 400) begin
            step(1'b0, 1'b1, 1'b0, d);
            n++;
        end
        checks++;
        if (!(md_v == v && (w < 0 || md_wd == w))) begin
            errors++;
            $display("FAIL goto: model at day %0d wd %0d, required day %0d wd %0d", md_v, md_wd, v, w);
        end
    endtask

    task automatic check_out(input string name, input int v, input int c, input int w, input int cl);
        checks++;
        if (value !== 5'(v) || carry_out !== 1'(c) || weekday !== 3'(w) || clamp_event !== 1'(cl)) begin
            errors++;
            $display("FAIL %s: got value=%0d carry=%0b wd=%0d clamp=%0b, required value=%0d carry=%0d wd=%0d clamp=%0d",
                     name, value, carry_out, weekday, clamp_event, v, c, w, cl);
        end
    endtask

    task automatic test_reset();
        goto_state(17, -1, 31);
        #3;
        rst = 1'b1;
        #1;
        md_v  = 1;
        md_wd = WD_R;
        check_out("reset_async", 1, 0, WD_R, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 31);
        end
        check_out("reset_idle", 1, 0, WD_R, 0);
    endtask

    task automatic test_auto_rollover();
        goto_state(30, 6, 30);
        step(1'b1, 1'b0, 1'b0, 30);
        check_out("rollover", 1, 1, 0, 0);
        step(1'b0, 1'b0, 1'b0, 30);
        check_out("rollover_carry_drop", 1, 0, 0, 0);
    endtask

    task automatic test_feb();
        int n_carry;
        int carry_at;
        n_carry  = 0;
        carry_at = 0;
        goto_state(1, -1, 28);
        for (int i = 1; i <= 28; i++) begin
            step(1'b1, 1'b0, 1'b0, 28);
            if (carry_out === 1'b1) begin
                n_carry++;
                carry_at = i;
            end
        end
        checks++;
        if (n_carry != 1 || carry_at != 28 || value !== 5'd1) begin
            errors++;
            $display("FAIL feb: got %0d carries, last at pulse %0d, value=%0d; required 1 carry at pulse 28, value=1",
                     n_carry, carry_at, value);
        end
    endtask

    task automatic test_clamp();
        int wd0;
        goto_state(31, -1, 31);
        wd0 = md_wd;
        step(1'b0, 1'b0, 1'b0, 29);
        check_out("clamp", 29, 0, wd0, 1);
        step(1'b0, 1'b0, 1'b0, 29);
        check_out("clamp_drop", 29, 0, wd0, 0);
    endtask

    task automatic test_clamp_with_cmd();
        int wd0;
        goto_state(31, -1, 31);
        wd0 = md_wd;
        step(1'b1, 1'b0, 1'b0, 30);
        check_out("clamp_cmd", 1, 1, (wd0 + 1) % 7, 1);
    endtask

    task automatic test_priority();
        goto_state(1, 0, 31);
        step(1'b1, 1'b0, 1'b1, 31);
        check_out("prio_dec_over_auto", 31, 0, 6, 0);
        step(1'b0, 1'b1, 1'b0, 31);
        check_out("manual_wrap", 1, 0, 0, 0);
        step(1'b1, 1'b1, 1'b0, 31);
        check_out("prio_inc_over_auto", 2, 0, 1, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 4) == 0),
                 1'($urandom_range(0, 5) == 0), (i % 40 < 30) ? 31 : int'($urandom_range(26, 33)));
        end
    endtask

    initial begin
        rst        = 1'b1;
        inc_auto   = 1'b0;
        inc_manual = 1'b0;
        dec_manual = 1'b0;
        dim        = 6'd31;
        md_v       = 1;
        md_wd      = WD_R;
        repeat (2) @(posedge clk);
        #1;
        check_out("reset_state", 1, 0, WD_R, 0);
        rst = 1'b0;

        test_reset();
        test_auto_rollover();
        test_feb();
        test_clamp();
        test_clamp_with_cmd();
        test_priority();
        test_random();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/counter_ngay.md
Name: counter_ngay

Overview:
- Day-of-month counter for the calendar chain. Consumes the days-in-month value produced by the month counter and issues the carry pulse that advances the month.
- Tracks day-of-week (0..6) alongside the day value.
- Clamps the day when the month or leap status shrinks the month length.
- Sits between the hour counter (its carry drives inc_auto) and the month counter (fed by carry_out).

Parameters:
- WD_RESET, 0, weekday loaded at reset (0 = Monday .. 6 = Sunday).
- DIM_DEFAULT, 31, month length used when dim input is out of range.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- inc_auto  in  1  one-cycle pulse from hour-counter rollover.
- inc_manual  in  1  one-cycle pulse, user day +1.
- dec_manual  in  1  one-cycle pulse, user day -1.
- dim  in  6  days in current month from month counter (28..31).
- value  out  5  current day, 1..dim.
- carry_out  out  1  one-cycle pulse when an auto increment wraps to day 1.
- weekday  out  3  day of week, 0..6.
- clamp_event  out  1  one-cycle pulse when value was forced down to dim.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: value=1, carry_out=0, weekday=WD_RESET, clamp_event=0. All outputs are registered.
- Effective month length L = dim if 28<=dim<=31, else DIM_DEFAULT. Evaluate every cycle.
- Effective day E = min(value, L). All operations in a cycle act on E, never on the stale value.
- Command priority per cycle: dec_manual > inc_manual > inc_auto. Only the highest asserted command is applied; the others are dropped.
- inc_auto:
  - E==L gives value<=1, carry_out<=1.
  - Otherwise value<=E+1.
  - weekday +1 mod 7.
- inc_manual:
  - E==L gives value<=1 and no carry.
  - Otherwise value<=E+1.
  - weekday +1 mod 7.
- dec_manual:
  - E==1 gives value<=L.
  - Otherwise value<=E-1.
  - weekday -1 mod 7 (0 goes to 6). No carry.
- No command and value>L: value<=L, clamp_event<=1, weekday unchanged.
- Command and value>L in the same cycle: clamp_event<=1 and the command acts on E=L. Example: value 31, dim 30, inc_auto gives value 1, carry 1, clamp 1.
- carry_out and clamp_event default to 0 every cycle. Each is high for exactly one cycle, in the same cycle the new value appears.
- Latency: a command pulse in cycle N updates outputs at edge N+1.
- Multi-cycle pulses are treated as one command per cycle. Edge detection is the responsibility of upstream.
- Reset asserted mid-operation: all outputs return to reset values immediately. A pending carry is discarded.
- value never leaves 1..31 and never exceeds L for more than one cycle after dim changes.

Decomposition:
- calendar_pkg:
  - DAY_MIN=1, DAY_MAX=31, WD_W=3, WD_MOD=7.
  - Month-length constants 28/29/30/31.
  - Function for mod-7 increment/decrement.
- Sub-module weekday_ctr: mod-7 up/down counter.
  - Ports: clk, rst, up, down, q.
  - Driven by the same command decode as value.

Test Plan:
- Reset: assert rst mid-count with value 17 -> value=1, weekday=WD_RESET, carry_out=0 immediately; release and hold idle -> no change.
- Auto rollover: dim=30, value=30, weekday=6, inc_auto pulse -> next cycle value=1, carry_out=1 for one cycle only, weekday=0.
- Feb non-leap: dim=28, 28 inc_auto pulses from day 1 -> exactly one carry_out, on the 28th pulse; value=1.
- Clamp: value=31, dim switches to 29 with no command -> value=29, clamp_event=1 one cycle, weekday unchanged.
- Clamp with command: value=31, dim=30, inc_auto same cycle -> value=1, carry_out=1, clamp_event=1.
- Priority and manual wrap: value=1, weekday=0, dec_manual and inc_auto together, dim=31 -> value=31, weekday=6, carry_out=0. Then inc_manual at 31 -> value=1, carry_out=0.
